// File: rtl/axis_pkt_arbiter.sv
// Packet-granular round-robin arbiter: merges NUM_S AXI-Stream slave ports onto one master port.
// A grant is held from the first beat to the tlast handshake; one bubble cycle separates arbitration from data.
module axis_pkt_arbiter #(
  parameter int NUM_S       = 4,
  parameter int TDATA_WIDTH = 4,
  parameter int TID_WIDTH   = 1,
  parameter int TDEST_WIDTH = 1,
  localparam int SEL_W      = (NUM_S > 1) ? $clog2(NUM_S) : 1
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic [NUM_S-1:0]                   s_axis_tvalid,
  output logic [NUM_S-1:0]                   s_axis_tready,
  input  logic [NUM_S*TDATA_WIDTH*8-1:0]     s_axis_tdata,
  input  logic [NUM_S*TDATA_WIDTH-1:0]       s_axis_tkeep,
  input  logic [NUM_S*TDATA_WIDTH-1:0]       s_axis_tstrb,
  input  logic [NUM_S-1:0]                   s_axis_tlast,
  input  logic [NUM_S*TID_WIDTH-1:0]         s_axis_tid,
  input  logic [NUM_S*TDEST_WIDTH-1:0]       s_axis_tdest,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic [TDATA_WIDTH*8-1:0]           m_axis_tdata,
  output logic [TDATA_WIDTH-1:0]             m_axis_tkeep,
  output logic [TDATA_WIDTH-1:0]             m_axis_tstrb,
  output logic                               m_axis_tlast,
  output logic [TID_WIDTH-1:0]               m_axis_tid,
  output logic [TDEST_WIDTH-1:0]             m_axis_tdest,
  output logic [SEL_W-1:0]                   m_axis_tsrc,
  output logic                               busy
);

  localparam int DW = TDATA_WIDTH * 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_XFER  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] grant_q, grant_d;
  logic [SEL_W-1:0] last_grant_q, last_grant_d;

  logic             rr_found_s;
  logic [SEL_W-1:0] rr_pick_s;
  logic [SEL_W-1:0] rr_idx_s;
  logic             sel_valid_s;
  logic             sel_last_s;
  logic             last_hs_s;

  // Round-robin search starting just after the previous winner; the previous winner is tried last.
  always_comb begin
    rr_found_s = 1'b0;
    rr_pick_s  = '0;
    rr_idx_s   = '0;
    for (int k = 1; k <= NUM_S; k++) begin
      rr_idx_s = SEL_W'((int'(last_grant_q) + k) % NUM_S);
      if (!rr_found_s && s_axis_tvalid[rr_idx_s]) begin
        rr_found_s = 1'b1;
        rr_pick_s  = rr_idx_s;
      end
    end
  end

  assign sel_valid_s = s_axis_tvalid[grant_q];
  assign sel_last_s  = s_axis_tlast[grant_q];
  assign last_hs_s   = sel_valid_s && m_axis_tready && sel_last_s;

  // State, grant and round-robin pointer registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= SEL_W'(NUM_S - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state logic; the grant only moves in IDLE, so requests arriving mid-packet wait.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (rr_found_s) begin
          grant_d = rr_pick_s;
          state_d = ST_GRANT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: state_d = ST_XFER;
      ST_XFER: begin
        if (last_hs_s) begin
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_XFER;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath mux: transparent connection of the granted port during XFER, zeros otherwise.
  always_comb begin
    s_axis_tready = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tstrb  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tid    = '0;
    m_axis_tdest  = '0;
    if (state_q == ST_XFER) begin
      s_axis_tready[grant_q] = m_axis_tready;
      m_axis_tvalid = sel_valid_s;
      m_axis_tdata  = s_axis_tdata[int'(grant_q)*DW +: DW];
      m_axis_tkeep  = s_axis_tkeep[int'(grant_q)*TDATA_WIDTH +: TDATA_WIDTH];
      m_axis_tstrb  = s_axis_tstrb[int'(grant_q)*TDATA_WIDTH +: TDATA_WIDTH];
      m_axis_tlast  = sel_last_s;
      m_axis_tid    = s_axis_tid[int'(grant_q)*TID_WIDTH +: TID_WIDTH];
      m_axis_tdest  = s_axis_tdest[int'(grant_q)*TDEST_WIDTH +: TDEST_WIDTH];
    end else begin
      s_axis_tready = '0;
    end
  end

  assign m_axis_tsrc = grant_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Directed bench for axis_pkt_arbiter: per-port packet sources driven from tasks, outputs checked on the falling edge.
module tb_axis_pkt_arbiter;

  logic         aclk;
  logic         aresetn;
  logic [3:0]   s_tvalid;
  logic [3:0]   s_tready;
  logic [127:0] s_tdata;
  logic [15:0]  s_tkeep;
  logic [15:0]  s_tstrb;
  logic [3:0]   s_tlast;
  logic [15:0]  s_tid;
  logic [15:0]  s_tdest;
  logic         m_tvalid;
  logic         m_tready;
  logic [31:0]  m_tdata;
  logic [3:0]   m_tkeep;
  logic [3:0]   m_tstrb;
  logic         m_tlast;
  logic [3:0]   m_tid;
  logic [3:0]   m_tdest;
  logic [1:0]   m_tsrc;
  logic         busy;

  int rem[4];
  int beat[4];
  int reload[4];
  logic [3:0] gap;
  int checks;
  int errors;

  axis_pkt_arbiter #(
    .NUM_S(4), .TDATA_WIDTH(4), .TID_WIDTH(4), .TDEST_WIDTH(4)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
    .s_axis_tkeep(s_tkeep), .s_axis_tstrb(s_tstrb), .s_axis_tlast(s_tlast),
    .s_axis_tid(s_tid), .s_axis_tdest(s_tdest),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .m_axis_tkeep(m_tkeep), .m_axis_tstrb(m_tstrb), .m_axis_tlast(m_tlast),
    .m_axis_tid(m_tid), .m_axis_tdest(m_tdest), .m_axis_tsrc(m_tsrc), .busy(busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic logic [31:0] exp_data(input int p, input int b);
    return 32'hD000_5A3C | (32'(p) << 24) | (32'(b & 255) << 16);
  endfunction

  function automatic logic [3:0] exp_dest(input int p, input int b);
    return 4'(b + 3 * p);
  endfunction

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      s_tvalid[i]          = (rem[i] > 0) && !gap[i];
      s_tlast[i]           = (rem[i] == 1);
      s_tdata[i*32 +: 32]  = exp_data(i, beat[i]);
      s_tkeep[i*4 +: 4]    = 4'hF;
      s_tstrb[i*4 +: 4]    = 4'(beat[i] + 1);
      s_tid[i*4 +: 4]      = 4'(i + 5);
      s_tdest[i*4 +: 4]    = exp_dest(i, beat[i]);
    end
  endtask

  // One clock: note handshakes before the edge, advance sources after it, return on the falling edge.
  task automatic clk();
    logic [3:0] hs;
    #1;
    hs = s_tvalid & s_tready;
    @(posedge aclk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (hs[i]) begin
        beat[i] = beat[i] + 1;
        rem[i]  = rem[i] - 1;
        if (rem[i] == 0) rem[i] = reload[i];
      end
    end
    drive();
    @(negedge aclk);
  endtask

  task automatic clear_sources();
    for (int i = 0; i < 4; i++) begin
      rem[i] = 0; beat[i] = 0; reload[i] = 0;
    end
    gap = 4'b0000;
    drive();
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    clear_sources();
    @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    aresetn  = 1'b0;
    m_tready = 1'b1;
    clear_sources();
    rem[0] = 1;
    drive();
    @(posedge aclk); @(posedge aclk); @(negedge aclk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", busy); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %0b exp 0", m_tvalid); end
    checks++; if (s_tready !== 4'b0000) begin errors++; $display("FAIL rst_sready got %b exp 0000", s_tready); end
    checks++; if (m_tsrc !== 2'd0) begin errors++; $display("FAIL rst_tsrc got %0d exp 0", m_tsrc); end
    checks++; if (m_tlast !== 1'b0 || m_tdata !== 32'h0) begin errors++; $display("FAIL rst_data got last %0b data %h exp 0/0", m_tlast, m_tdata); end
    rem[0] = 0;
    drive();
    aresetn = 1'b1;
  endtask

  task automatic test_priority();
    rem[0] = 3; rem[2] = 3;
    drive();
    #1;
    checks++; if (busy !== 1'b0 || m_tvalid !== 1'b0) begin errors++; $display("FAIL pri_idle got busy %0b tvalid %0b exp 0/0", busy, m_tvalid); end
    clk();
    checks++; if (busy !== 1'b1 || m_tvalid !== 1'b0 || s_tready !== 4'b0000) begin errors++; $display("FAIL pri_bubble got busy %0b tvalid %0b tready %b exp 1/0/0000", busy, m_tvalid, s_tready); end
    checks++; if (m_tdata !== 32'h0) begin errors++; $display("FAIL pri_bubble_data got %h exp 0", m_tdata); end
    clk();
    for (int b = 0; b < 3; b++) begin
      checks++; if (m_tvalid !== 1'b1 || m_tsrc !== 2'd0) begin errors++; $display("FAIL pri_p0_src beat %0d got tvalid %0b src %0d exp 1/0", b, m_tvalid, m_tsrc); end
      checks++; if (m_tdata !== exp_data(0, b) || m_tlast !== (b == 2)) begin errors++; $display("FAIL pri_p0_data beat %0d got %h last %0b exp %h last %0b", b, m_tdata, m_tlast, exp_data(0, b), (b == 2)); end
      checks++; if (s_tready !== 4'b0001 || m_tstrb !== 4'(b + 1)) begin errors++; $display("FAIL pri_p0_ready beat %0d got tready %b strb %h exp 0001 %h", b, s_tready, m_tstrb, 4'(b + 1)); end
      clk();
    end
    checks++; if (busy !== 1'b0 || m_tvalid !== 1'b0) begin errors++; $display("FAIL pri_gap_idle got busy %0b tvalid %0b exp 0/0", busy, m_tvalid); end
    clk();
    checks++; if (busy !== 1'b1 || m_tvalid !== 1'b0) begin errors++; $display("FAIL pri_gap_grant got busy %0b tvalid %0b exp 1/0", busy, m_tvalid); end
    clk();
    for (int b = 0; b < 3; b++) begin
      checks++; if (m_tvalid !== 1'b1 || m_tsrc !== 2'd2) begin errors++; $display("FAIL pri_p2_src beat %0d got tvalid %0b src %0d exp 1/2", b, m_tvalid, m_tsrc); end
      checks++; if (m_tdata !== exp_data(2, b) || m_tlast !== (b == 2) || m_tid !== 4'd7) begin errors++; $display("FAIL pri_p2_data beat %0d got %h last %0b id %0d exp %h %0b 7", b, m_tdata, m_tlast, m_tid, exp_data(2, b), (b == 2)); end
      clk();
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pri_end_busy got %0b exp 0", busy); end
  endtask

  task automatic test_sampling();
    rem[1] = 1; beat[1] = 0;
    drive();
    #2;
    rem[1] = 0;
    drive();
    clk();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sample_nolatch got busy %0b exp 0", busy); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rem[i] = 1; reload[i] = 1;
    end
    drive();
    for (int g = 0; g < 8; g++) begin
      clk();
      checks++; if (busy !== 1'b1 || m_tvalid !== 1'b0) begin errors++; $display("FAIL rr_grant_cyc %0d got busy %0b tvalid %0b exp 1/0", g, busy, m_tvalid); end
      clk();
      checks++; if (m_tvalid !== 1'b1 || m_tsrc !== 2'(g % 4) || m_tlast !== 1'b1) begin errors++; $display("FAIL rr_beat %0d got tvalid %0b src %0d last %0b exp 1/%0d/1", g, m_tvalid, m_tsrc, m_tlast, g % 4); end
      clk();
      checks++; if (busy !== 1'b0 || m_tvalid !== 1'b0) begin errors++; $display("FAIL rr_idle_cyc %0d got busy %0b tvalid %0b exp 0/0", g, busy, m_tvalid); end
    end
    clear_sources();
  endtask

  task automatic test_backpressure();
    int   exp_b;
    logic exp_v;
    rem[1] = 4; beat[1] = 0; m_tready = 1'b1;
    drive();
    clk();
    clk();
    exp_b = 0;
    for (int c = 0; c < 20; c++) begin
      if (exp_b == 4) break;
      m_tready = (c % 2 == 0);
      gap[1]   = (c == 3 || c == 4);
      drive();
      #1;
      exp_v = !gap[1];
      checks++; if (m_tvalid !== exp_v || m_tsrc !== 2'd1 || busy !== 1'b1) begin errors++; $display("FAIL bp_hold cyc %0d got tvalid %0b src %0d busy %0b exp %0b/1/1", c, m_tvalid, m_tsrc, busy, exp_v); end
      checks++; if (s_tready !== {2'b00, m_tready, 1'b0}) begin errors++; $display("FAIL bp_sready cyc %0d got %b exp %b", c, s_tready, {2'b00, m_tready, 1'b0}); end
      if (exp_v) begin
        checks++; if (m_tdata !== exp_data(1, exp_b) || m_tid !== 4'd6 || m_tdest !== exp_dest(1, exp_b) || m_tlast !== (exp_b == 3)) begin
          errors++; $display("FAIL bp_beat cyc %0d got data %h id %0d dest %0d last %0b exp beat %0d data %h id 6 dest %0d", c, m_tdata, m_tid, m_tdest, m_tlast, exp_b, exp_data(1, exp_b), exp_dest(1, exp_b));
        end
      end else begin
        exp_v = 1'b0;
      end
      if (exp_v && m_tready) exp_b++;
      clk();
    end
    gap = 4'b0000; m_tready = 1'b1;
    drive();
    checks++; if (exp_b != 4 || beat[1] != 4) begin errors++; $display("FAIL bp_count got bench %0d source %0d exp 4/4", exp_b, beat[1]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_release got busy %0b exp 0", busy); end
  endtask

  task automatic test_no_preempt();
    rem[1] = 3; beat[1] = 0;
    drive();
    clk();
    clk();
    rem[3] = 1; beat[3] = 0;
    drive();
    #1;
    for (int b = 0; b < 3; b++) begin
      checks++; if (m_tsrc !== 2'd1 || s_tready !== 4'b0010) begin errors++; $display("FAIL np_hold beat %0d got src %0d tready %b exp 1/0010", b, m_tsrc, s_tready); end
      checks++; if (m_tdata !== exp_data(1, b)) begin errors++; $display("FAIL np_data beat %0d got %h exp %h", b, m_tdata, exp_data(1, b)); end
      clk();
    end
    checks++; if (busy !== 1'b0 || s_tready[3] !== 1'b0) begin errors++; $display("FAIL np_idle got busy %0b tready3 %0b exp 0/0", busy, s_tready[3]); end
    clk();
    clk();
    checks++; if (m_tsrc !== 2'd3 || s_tready !== 4'b1000 || m_tvalid !== 1'b1) begin errors++; $display("FAIL np_p3 got src %0d tready %b tvalid %0b exp 3/1000/1", m_tsrc, s_tready, m_tvalid); end
    checks++; if (m_tdata !== exp_data(3, 0) || m_tlast !== 1'b1) begin errors++; $display("FAIL np_p3_data got %h last %0b exp %h 1", m_tdata, m_tlast, exp_data(3, 0)); end
    clk();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL np_end got busy %0b exp 0", busy); end
  endtask

  task automatic test_reset_mid();
    rem[2] = 4; beat[2] = 0;
    drive();
    clk();
    clk();
    checks++; if (m_tsrc !== 2'd2 || m_tdata !== exp_data(2, 0)) begin errors++; $display("FAIL rm_beat1 got src %0d data %h exp 2 %h", m_tsrc, m_tdata, exp_data(2, 0)); end
    clk();
    checks++; if (m_tdata !== exp_data(2, 1) || m_tvalid !== 1'b1) begin errors++; $display("FAIL rm_beat2 got data %h tvalid %0b exp %h 1", m_tdata, m_tvalid, exp_data(2, 1)); end
    aresetn = 1'b0;
    #1;
    checks++; if (m_tvalid !== 1'b0 || busy !== 1'b0 || s_tready !== 4'b0000) begin errors++; $display("FAIL rm_async got tvalid %0b busy %0b tready %b exp 0/0/0000", m_tvalid, busy, s_tready); end
    checks++; if (m_tsrc !== 2'd0 || m_tlast !== 1'b0 || m_tdata !== 32'h0) begin errors++; $display("FAIL rm_async_data got src %0d last %0b data %h exp 0/0/0", m_tsrc, m_tlast, m_tdata); end
    @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    clear_sources();
    rem[0] = 2; rem[2] = 2;
    drive();
    clk();
    clk();
    checks++; if (m_tsrc !== 2'd0 || m_tvalid !== 1'b1 || m_tdata !== exp_data(0, 0)) begin errors++; $display("FAIL rm_regrant got src %0d tvalid %0b data %h exp 0/1/%h", m_tsrc, m_tvalid, m_tdata, exp_data(0, 0)); end
    clk();
    clk();
    rem[2] = 0;
    drive();
    clk();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_end got busy %0b exp 0", busy); end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    aresetn  = 1'b0;
    m_tready = 1'b0;
    clear_sources();
    @(negedge aclk);
    test_reset();
    test_priority();
    test_sampling();
    test_round_robin();
    test_backpressure();
    test_no_preempt();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
